deinterleaver: RTL and testbench
================================

Name: deinterleaver

Overview:
Receive-side block-deinterleaver for the WiMAX PHY chain (802.16 OFDM). It sits between the QPSK demapper and the FEC decoder. Coded bits arrive in interleaved (over-the-air) order, one per cycle. Each bit is written into a ping-pong buffer at its original index k. Completed blocks of Ncbps bits are streamed out in natural order (k = 0..Ncbps-1). Valid/ready handshakes are used on both sides.

Parameters:
- Ncbps, 192, coded bits per block (block length).
- Ncpc, 2, coded bits per carrier (QPSK).
- s, Ncpc/2, permutation granularity.
- d, 16, interleaver column count.

Ports:
- clk  input  1  system clock, rising edge.
- resetN  input  1  asynchronous, active-low reset.
- data_in  input  1  demapped coded bit, interleaved order.
- valid_demapper  input  1  data_in valid.
- ready_deinterleaver  output  1  block can accept a bit this cycle.
- data_out  output  1  deinterleaved bit.
- data_out_index  output  $clog2(Ncbps)  original index k of data_out.
- valid_deinterleaver  output  1  data_out/data_out_index valid.
- ready_fec  input  1  downstream FEC accepts the bit this cycle.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (resetN).
- Storage: two banks of Ncbps bits (bank0, bank1). Each bank has a full flag. Pointers: wr_bank, rd_bank, wr_j (0..Ncbps-1), rd_k (0..Ncbps-1).
- Reset values: all counters 0; wr_bank = rd_bank = 0; both full flags 0.
  - Outputs under reset: ready_deinterleaver = 1, valid_deinterleaver = 0, data_out_index = 0, data_out = bank0[0].
  - Bank contents are not reset and are don't-care.
- Index map for input position j, per 802.16:
  - m = s*floor(j/s) + (j + floor(d*j/Ncbps)) mod s
  - k = d*m - (Ncbps-1)*floor(d*m/Ncbps)
  - Intermediate products use at least $clog2(d*Ncbps)+1 bits and are truncated only at the final assignment.
  - Defaults (s = 1): m = j and k = 16*(j mod 12) + floor(j/12).
- Write side:
  - ready_deinterleaver = !full[wr_bank], purely combinational from flops.
  - Accept when valid_demapper && ready_deinterleaver. The bank[wr_bank][k(wr_j)] <= data_in.
  - When wr_j == Ncbps-1 on accept: wr_j <= 0, full[wr_bank] <= 1, wr_bank toggles. Otherwise wr_j increments.
  - No accept means no state change.
- Read side:
  - valid_deinterleaver = full[rd_bank].
  - data_out = bank[rd_bank][rd_k] and data_out_index = rd_k, both combinational from flops.
  - Transfer when valid_deinterleaver && ready_fec.
  - When rd_k == Ncbps-1 on transfer: rd_k <= 0, full[rd_bank] <= 0, rd_bank toggles. Otherwise rd_k increments.
- Latency: first output bit (k = 0) is valid the cycle after the last input bit (j = Ncbps-1) of that block is accepted.
- Throughput: sustained 1 bit/cycle in and out with no bubbles when ready_fec is held high.
- Simultaneous events:
  - A write completing one bank and a read completing the other bank in the same cycle are both honoured. The full flags update independently (set one, clear the other).
  - Writing into the bank being read is impossible by construction: that bank is full, so ready is low.
- Backpressure: with ready_fec low, at most 2*Ncbps bits are accepted. ready_deinterleaver then stays low until the read bank drains completely.
- Reset mid-block: any partial block is discarded and the block returns to the reset state. No output is produced for the partial block.
- Out-of-range: the counters never exceed Ncbps-1. The constant 8'd191 must not be hard-coded; compare against Ncbps-1.

Decomposition:
- Shared package wimax_pkg holds:
  - Constants NCBPS, NCPC, D and the index width localparam.
  - Pure functions int_index(k) (the transmit map) and deint_index(j) (the map above), so the RTL and the bench share one definition.
- One sub-module: deint_index_gen, combinational j -> k with the same parameters. It is instantiated once on the write side and is unit-testable on its own.

Test Plan:
- Index map: drive wr_j over 0..191. Required k values: j=0 -> 0, j=1 -> 16, j=11 -> 176, j=12 -> 1, j=13 -> 17, j=191 -> 191. Every k 0..191 hit exactly once.
- Single block with ready_fec = 1: input bit 1 only at j = 1, all others 0. Required output: data_out = 1 only at data_out_index = 16. valid_deinterleaver rises the cycle after j = 191 is accepted and stays high for exactly 192 cycles.
- Round trip: random 192-bit blocks are permuted by the transmit interleaver map and fed back-to-back for 10 blocks. Required: outputs equal the original bits in order, and ready_deinterleaver never drops.
- Backpressure: ready_fec = 0 with 400 bits offered. Required: exactly 384 accepted and ready_deinterleaver low from then on. After ready_fec = 1, it rises the cycle after the 192nd output transfer.
- Simultaneous completion: align the last write of bank1 with the last read of bank0. Required: full = {1,0} to {0,1} swap in one cycle, and no lost or duplicated bit.
- Reset mid-operation: assert resetN low after 100 input bits. Required: valid_deinterleaver = 0 and ready_deinterleaver = 1 immediately. The next full block is output correctly starting at index 0.

Source files
------------

// File: rtl/wimax_pkg.sv
// Shared constants and index maps for the 802.16 OFDM block (de)interleaver.
// RTL and bench both reach the permutation through these functions.
package wimax_pkg;
  localparam int NCBPS = 192;
  localparam int NCPC  = 2;
  localparam int S     = NCPC / 2;
  localparam int D     = 16;
  localparam int IDX_W = $clog2(NCBPS);

  // Receive map: over-the-air position j -> original index k.
  // int intermediates are far wider than D*NCBPS needs; truncated only on return.
  function automatic logic [IDX_W-1:0] deint_index(input logic [IDX_W-1:0] j);
    int jj, m, k;
    jj = int'(j);
    m  = S * (jj / S) + ((jj + (D * jj) / NCBPS) % S);
    k  = D * m - (NCBPS - 1) * ((D * m) / NCBPS);
    return IDX_W'(k);
  endfunction

  // Transmit map: original index k -> over-the-air position j.
  function automatic logic [IDX_W-1:0] int_index(input logic [IDX_W-1:0] k);
    int kk, m, j;
    kk = int'(k);
    m  = (NCBPS / D) * (kk % D) + kk / D;
    j  = S * (m / S) + ((m + NCBPS - (D * m) / NCBPS) % S);
    return IDX_W'(j);
  endfunction
endpackage

// File: rtl/deinterleaver_if.sv
// Bit-serial handshake bundle: demapper -> deinterleaver -> FEC.
interface deinterleaver_if;
  import wimax_pkg::*;
  logic             data_in;
  logic             valid_demapper;
  logic             ready_deinterleaver;
  logic             data_out;
  logic [IDX_W-1:0] data_out_index;
  logic             valid_deinterleaver;
  logic             ready_fec;

  modport master (
    output data_in, valid_demapper, ready_fec,
    input  ready_deinterleaver, data_out, data_out_index, valid_deinterleaver
  );
  modport slave (
    input  data_in, valid_demapper, ready_fec,
    output ready_deinterleaver, data_out, data_out_index, valid_deinterleaver
  );
endinterface

// File: rtl/deint_index_gen.sv
// Combinational write-address generator: input position j -> original index k.
module deint_index_gen
  import wimax_pkg::*;
(
  input  logic [IDX_W-1:0] j,
  output logic [IDX_W-1:0] k
);
  assign k = deint_index(j);
endmodule

// File: rtl/deinterleaver.sv
// Ping-pong block deinterleaver: bits land at their original index in the
// write bank, a full bank is streamed out in natural order.
module deinterleaver
  import wimax_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  deinterleaver_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCBPS - 1);

  logic [1:0][NCBPS-1:0] bank;
  logic [1:0]            full;
  logic                  wr_bank, rd_bank;
  logic [IDX_W-1:0]      wr_j, rd_k, wr_k;
  logic                  wr_acc, rd_xfer;

  deint_index_gen u_idx (.j(wr_j), .k(wr_k));

  assign bus.ready_deinterleaver = !full[wr_bank];
  assign bus.valid_deinterleaver = full[rd_bank];
  assign bus.data_out            = bank[rd_bank][rd_k];
  assign bus.data_out_index      = rd_k;

  assign wr_acc  = bus.valid_demapper && !full[wr_bank];
  assign rd_xfer = full[rd_bank] && bus.ready_fec;

  // Storage is not reset: a bank is only read after it has been fully rewritten.
  always_ff @(posedge clk) begin
    if (wr_acc) bank[wr_bank][wr_k] <= bus.data_in;
  end

  // When both sides complete a block in one cycle they touch different banks,
  // since the write bank must be empty and the read bank full.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_j    <= '0;
      rd_k    <= '0;
    end else begin
      if (wr_acc) begin
        if (wr_j == LAST) begin
          wr_j          <= '0;
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end else begin
          wr_j <= wr_j + IDX_W'(1);
        end
      end
      if (rd_xfer) begin
        if (rd_k == LAST) begin
          rd_k          <= '0;
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end else begin
          rd_k <= rd_k + IDX_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_deinterleaver.sv
// Self-checking bench: index-map table, randomized round trips against a
// permutation model, backpressure, simultaneous bank swap and mid-block reset.
module tb_deinterleaver;
  import wimax_pkg::*;

  localparam int N = 192;

  logic clk, resetN;
  deinterleaver_if dif ();
  deinterleaver dut (.clk(clk), .resetN(resetN), .bus(dif));

  logic [7:0] gj, gk;
  deint_index_gen u_gen (.j(gj), .k(gk));

  always #5 clk = ~clk;

  int checks, errors;

  // reference model state
  bit   in_buf [N];
  bit   exp_q [$];
  int   wj, exp_idx;
  int   one_cnt, one_idx;
  bit   s_valid, s_ready, last_acc, last_xfer;
  logic [1:0] s_full, prev_full;
  int   swaps, pre_valid;
  bit   stream [2048];

  typedef struct { int j; int k; } map_vec_t;
  map_vec_t tbl [6];

  // Spec-level map for the default parameters.
  function automatic int kmap(input int j);
    return 16 * (j % 12) + j / 12;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_in(input bit b);
    bit blk [N];
    in_buf[wj] = b;
    if (wj == N - 1) begin
      for (int j = 0; j < N; j++) blk[kmap(j)] = in_buf[j];
      for (int k = 0; k < N; k++) exp_q.push_back(blk[k]);
      wj = 0;
    end else wj++;
  endtask

  task automatic check_out();
    bit e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL spurious_output: idx %0d with no block expected", dif.data_out_index);
    end else begin
      e = exp_q.pop_front();
      if (dif.data_out !== e || int'(dif.data_out_index) != exp_idx) begin
        errors++;
        $display("FAIL out_bit: got bit %0b idx %0d expected bit %0b idx %0d",
                 dif.data_out, dif.data_out_index, e, exp_idx);
      end
    end
    if (dif.data_out === 1'b1) begin one_cnt++; one_idx = int'(dif.data_out_index); end
    exp_idx = (exp_idx == N - 1) ? 0 : exp_idx + 1;
  endtask

  // One clock: sample at negedge, model the edge, return #1 after posedge.
  task automatic tick();
    @(negedge clk);
    s_valid   = dif.valid_deinterleaver;
    s_ready   = dif.ready_deinterleaver;
    s_full    = dut.full;
    last_acc  = resetN && dif.valid_demapper && s_ready;
    last_xfer = resetN && s_valid && dif.ready_fec;
    if (last_xfer) check_out();
    if (last_acc)  model_in(dif.data_in);
    if ((prev_full == 2'b01 && s_full == 2'b10) || (prev_full == 2'b10 && s_full == 2'b01))
      swaps++;
    prev_full = s_full;
    @(posedge clk);
    #1;
  endtask

  // Offer stream[0..n-1] one bit per cycle; counts ready drops while feeding.
  task automatic feed(input string name, input int n, output int drops);
    int pos, cyc;
    pos = 0; cyc = 0; drops = 0; pre_valid = 0;
    while (pos < n && cyc < n + 1000) begin
      dif.data_in = stream[pos];
      dif.valid_demapper = 1'b1;
      tick();
      if (!s_ready) drops++;
      if (s_valid) pre_valid++;
      if (last_acc) pos++;
      cyc++;
    end
    dif.valid_demapper = 1'b0;
    chk(name, pos, n);
  endtask

  task automatic drain(input string name);
    int n;
    dif.valid_demapper = 1'b0;
    dif.ready_fec = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin tick(); n++; end
    chk({name, "_left"}, exp_q.size(), 0);
    tick();
    chk({name, "_valid_low"}, int'(s_valid), 0);
  endtask

  initial begin
    int drops, acc, bad, xf, vcnt, early;
    bit rise_chk;
    int hits [N];
    bit orig [N];

    checks = 0; errors = 0;
    clk = 0; resetN = 0;
    dif.data_in = 0; dif.valid_demapper = 0; dif.ready_fec = 0;
    wj = 0; exp_idx = 0; swaps = 0; prev_full = 2'b00;

    // ---- reset state
    #12;
    chk("rst_ready", int'(dif.ready_deinterleaver), 1);
    chk("rst_valid", int'(dif.valid_deinterleaver), 0);
    chk("rst_index", int'(dif.data_out_index), 0);

    // ---- index map table + exhaustive permutation check
    tbl[0] = '{0, 0};   tbl[1] = '{1, 16};  tbl[2] = '{11, 176};
    tbl[3] = '{12, 1};  tbl[4] = '{13, 17}; tbl[5] = '{191, 191};
    foreach (tbl[i]) begin
      gj = 8'(tbl[i].j); #1;
      chk($sformatf("map_j%0d", tbl[i].j), int'(gk), tbl[i].k);
    end
    bad = 0;
    for (int j = 0; j < N; j++) hits[j] = 0;
    for (int j = 0; j < N; j++) begin
      gj = 8'(j); #1;
      if (int'(gk) != kmap(j)) bad++;
      if (int'(gk) < N) hits[gk]++;
    end
    chk("map_all_j", bad, 0);
    bad = 0;
    for (int k = 0; k < N; k++) if (hits[k] != 1) bad++;
    chk("map_bijective", bad, 0);

    @(posedge clk); #1 resetN = 1;

    // ---- single block, only j=1 set
    dif.ready_fec = 1'b1;
    for (int j = 0; j < N; j++) stream[j] = (j == 1);
    one_cnt = 0; one_idx = -1;
    feed("single_accept", N, drops);
    chk("single_no_early_valid", pre_valid, 0);
    tick();
    chk("single_latency", int'(s_valid), 1);
    vcnt = s_valid ? 1 : 0;
    for (int c = 0; c < 300 && s_valid; c++) begin
      tick();
      if (s_valid) vcnt++;
    end
    chk("single_valid_len", vcnt, N);
    chk("single_ones", one_cnt, 1);
    chk("single_one_idx", one_idx, 16);
    chk("single_left", exp_q.size(), 0);

    // ---- round trip: 10 random blocks back to back, transmit-permuted
    swaps = 0;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < N; k++) orig[k] = 1'($urandom);
      for (int j = 0; j < N; j++) stream[b * N + j] = orig[kmap(j)];
    end
    feed("rt_accept", 10 * N, drops);
    chk("rt_ready_drops", drops, 0);
    drain("rt");
    chk("rt_bank_swaps", swaps, 9);

    // ---- backpressure: 400 bits offered with ready_fec low
    dif.ready_fec = 1'b0;
    acc = 0; bad = 0;
    for (int i = 0; i < 400; i++) begin
      dif.data_in = 1'($urandom);
      dif.valid_demapper = 1'b1;
      tick();
      if (acc >= 2 * N && s_ready) bad++;
      if (last_acc) acc++;
    end
    dif.valid_demapper = 1'b0;
    chk("bp_accepted", acc, 2 * N);
    chk("bp_ready_low", bad, 0);
    dif.ready_fec = 1'b1;
    xf = 0; early = 0; rise_chk = 0;
    for (int c = 0; c < 1000 && xf < 2 * N; c++) begin
      tick();
      if (xf < N && s_ready) early++;
      if (xf == N && !rise_chk) begin
        chk("bp_ready_rise", int'(s_ready), 1);
        rise_chk = 1;
      end
      if (last_xfer) xf++;
    end
    chk("bp_ready_early", early, 0);
    chk("bp_rise_seen", int'(rise_chk), 1);
    chk("bp_transfers", xf, 2 * N);
    drain("bp");

    // ---- reset after 100 input bits
    for (int j = 0; j < 100; j++) stream[j] = 1'($urandom);
    feed("rst_partial_accept", 100, drops);
    resetN = 1'b0;
    #1;
    chk("midrst_valid", int'(dif.valid_deinterleaver), 0);
    chk("midrst_ready", int'(dif.ready_deinterleaver), 1);
    wj = 0; exp_idx = 0;
    @(posedge clk); #1 resetN = 1'b1;
    for (int j = 0; j < N; j++) stream[j] = 1'($urandom);
    feed("midrst_accept", N, drops);
    drain("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
